// File: rtl/eth_rx_slot_ctrl.sv
// Multi-slot RX buffer controller: writes incoming frame octets into a slotted BRAM,
// keeps a per-slot length table and a producer/consumer ring with irq and drop counter.
module eth_rx_slot_ctrl #(
  parameter int unsigned SLOT_BITS = 2,
  parameter int unsigned MTU_BITS  = 11,
  parameter int unsigned W_LEN     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_start,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_last,
  input  logic                          rx_err,
  output logic                          mem_we,
  output logic [SLOT_BITS+MTU_BITS-1:0] mem_waddr,
  output logic [7:0]                    mem_wdata,
  output logic                          rd_avail,
  output logic [SLOT_BITS-1:0]          rd_slot,
  output logic [W_LEN-1:0]              rd_len,
  input  logic                          rd_pop,
  output logic [SLOT_BITS:0]            count,
  input  logic                          irq_en,
  output logic                          irq,
  output logic [15:0]                   drop_cnt,
  output logic                          busy
);

  localparam int unsigned        NSLOTS = 2**SLOT_BITS;
  localparam logic [SLOT_BITS:0] FULL   = (SLOT_BITS+1)'(NSLOTS);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  state_t                        state_q, state_d;
  logic [MTU_BITS-1:0]           wptr_q, wptr_d;
  logic [SLOT_BITS-1:0]          wr_slot_q, wr_slot_d;
  logic [SLOT_BITS-1:0]          rd_slot_q, rd_slot_d;
  logic [SLOT_BITS:0]            count_q, count_d;
  logic                          counted_q, counted_d;
  logic [15:0]                   drop_q, drop_d;
  logic                          irq_q;
  logic                          we_q, we_d;
  logic [SLOT_BITS+MTU_BITS-1:0] waddr_q, waddr_d;
  logic [7:0]                    wdata_q, wdata_d;
  logic [MTU_BITS:0]             len_q [NSLOTS];
  logic                          commit, drop, pop_ok, full;

  assign full   = (count_q == FULL);
  assign pop_ok = rd_pop && (count_q != '0);

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    counted_d = counted_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    commit    = 1'b0;
    drop      = 1'b0;
    // rx_start wins in every state: close out the current frame, then act as IDLE would
    if (rx_start) begin
      drop      = (state_q == RECV) || (state_q == DISCARD && !counted_q);
      counted_d = 1'b0;
      wptr_d    = '0;
      state_d   = full ? DISCARD : RECV;
    end else begin
      case (state_q)
        RECV: if (rx_valid) begin
          we_d    = 1'b1;
          waddr_d = {wr_slot_q, wptr_q};
          wdata_d = rx_data;
          wptr_d  = wptr_q + MTU_BITS'(1);
          if (rx_last) begin
            state_d = IDLE;
            commit  = !rx_err;
            drop    = rx_err;
          end else if (&wptr_q) begin
            drop      = 1'b1;
            counted_d = 1'b1;
            state_d   = DISCARD;
          end
        end
        DISCARD: if (rx_valid && rx_last) begin
          drop      = !counted_q;
          counted_d = 1'b0;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_slot_d = wr_slot_q + SLOT_BITS'(commit);
    rd_slot_d = rd_slot_q + SLOT_BITS'(pop_ok);
    count_d   = count_q;
    if (commit && !pop_ok)      count_d = count_q + (SLOT_BITS+1)'(1);
    else if (pop_ok && !commit) count_d = count_q - (SLOT_BITS+1)'(1);
    drop_d = (drop && drop_q != '1) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      wr_slot_q <= '0;
      rd_slot_q <= '0;
      count_q   <= '0;
      counted_q <= 1'b0;
      drop_q    <= '0;
      irq_q     <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      for (int unsigned i = 0; i < NSLOTS; i++) len_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      wr_slot_q <= wr_slot_d;
      rd_slot_q <= rd_slot_d;
      count_q   <= count_d;
      counted_q <= counted_d;
      drop_q    <= drop_d;
      irq_q     <= irq_en && (count_q != '0);
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      if (commit) len_q[wr_slot_q] <= (MTU_BITS+1)'(wptr_q) + (MTU_BITS+1)'(1);
    end
  end

  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign rd_avail  = (count_q != '0);
  assign rd_slot   = rd_slot_q;
  assign rd_len    = W_LEN'(len_q[rd_slot_q]);
  assign count     = count_q;
  assign irq       = irq_q;
  assign drop_cnt  = drop_q;
  assign busy      = (state_q != IDLE);

endmodule
